// File: rtl/ws_sa_pkg.sv
// Shared types and default widths for the weight-stationary systolic array PEs.
package ws_sa_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } pe_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2
  } pe_state_e;
endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 carry-save compressor; the carry out of the top bit is dropped (mod 2^WIDTH).
module csa_3to2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_c
);
  logic [WIDTH-2:0] w_maj;

  assign o_s   = i_x ^ i_y ^ i_z;
  assign w_maj = (i_x[WIDTH-2:0] & i_y[WIDTH-2:0]) |
                 (i_x[WIDTH-2:0] & i_z[WIDTH-2:0]) |
                 (i_y[WIDTH-2:0] & i_z[WIDTH-2:0]);
  assign o_c   = {w_maj, 1'b0};
endmodule

// File: rtl/ws_csa_pe.sv
// Systolic PE: stationary weight, carry-save psum. MODE_WS adds into the north psum,
// MODE_OS accumulates locally and resolves through a single CPA on drain.
import ws_sa_pkg::*;

module ws_csa_pe #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic              i_w_load,
  input  logic [DATA_W-1:0] i_w_in,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [DATA_W-1:0] i_a_in,
  input  logic [ACC_W-1:0]  i_ps_s_in,
  input  logic [ACC_W-1:0]  i_ps_c_in,
  output logic [DATA_W-1:0] o_a_out,
  output logic              o_a_out_vld,
  output logic [ACC_W-1:0]  o_ps_s_out,
  output logic [ACC_W-1:0]  o_ps_c_out,
  input  logic              i_drain,
  output logic [ACC_W-1:0]  o_res_data,
  output logic              o_res_valid
);
  pe_state_e r_state, w_state_nxt;
  pe_mode_e  r_mode, w_mode;

  logic [DATA_W-1:0] r_weight, r_a_out;
  logic              r_a_out_vld, r_res_valid;
  logic [ACC_W-1:0]  r_acc_s, r_acc_c, r_ps_s_out, r_ps_c_out, r_res_data;

  logic                       w_ready, w_accept, w_acc_en, w_ps_csa, w_resolve;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]           w_prod_ext, w_csa_x, w_csa_z, w_csa_s, w_csa_c;

  // Mode is only honoured in IDLE; once accumulating, the latched mode rules.
  assign w_mode   = (r_state == IDLE) ? pe_mode_e'(i_mode) : r_mode;
  assign w_ready  = (r_state != RESOLVE);
  assign w_accept = i_a_valid && w_ready;

  assign w_prod     = $signed(i_a_in) * $signed(r_weight);
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  csa_3to2 #(.WIDTH(ACC_W)) u_csa (
    .i_x (w_csa_x),
    .i_y (w_prod_ext),
    .i_z (w_csa_z),
    .o_s (w_csa_s),
    .o_c (w_csa_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_mode == MODE_OS) begin
          if (i_drain)       w_state_nxt = RESOLVE;
          else if (w_accept) w_state_nxt = ACC;
        end
      end
      ACC:     if (i_drain) w_state_nxt = RESOLVE;
      RESOLVE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_csa_x   = i_ps_s_in;
    w_csa_z   = i_ps_c_in;
    w_acc_en  = 1'b0;
    w_ps_csa  = 1'b0;
    w_resolve = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mode == MODE_OS) begin
          w_csa_x  = '0;
          w_csa_z  = '0;
          w_acc_en = w_accept;
        end else begin
          w_ps_csa = w_accept;
        end
      end
      ACC: begin
        w_csa_x  = r_acc_s;
        w_csa_z  = r_acc_c;
        w_acc_en = w_accept;
      end
      RESOLVE: w_resolve = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= MODE_WS;
      r_weight    <= '0;
      r_a_out     <= '0;
      r_a_out_vld <= 1'b0;
      r_ps_s_out  <= '0;
      r_ps_c_out  <= '0;
      r_acc_s     <= '0;
      r_acc_c     <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (r_state == IDLE) r_mode <= pe_mode_e'(i_mode);
      if (i_w_load)        r_weight <= i_w_in;
      if (w_accept)        r_a_out <= i_a_in;
      r_a_out_vld <= w_accept;
      if (w_ps_csa) begin
        r_ps_s_out <= w_csa_s;
        r_ps_c_out <= w_csa_c;
      end else begin
        r_ps_s_out <= i_ps_s_in;
        r_ps_c_out <= i_ps_c_in;
      end
      r_res_valid <= w_resolve;
      if (w_resolve) begin
        r_res_data <= r_acc_s + r_acc_c;
        r_acc_s    <= '0;
        r_acc_c    <= '0;
      end else if (w_acc_en) begin
        r_acc_s <= w_csa_s;
        r_acc_c <= w_csa_c;
      end
    end
  end

  assign o_a_ready   = w_ready;
  assign o_a_out     = r_a_out;
  assign o_a_out_vld = r_a_out_vld;
  assign o_ps_s_out  = r_ps_s_out;
  assign o_ps_c_out  = r_ps_c_out;
  assign o_res_data  = r_res_data;
  assign o_res_valid = r_res_valid;
endmodule

// File: tb/tb_ws_csa_pe.sv
// Bench for ws_csa_pe: directed scenarios plus random traffic against an integer-sum reference model.
module tb_ws_csa_pe;
  logic        i_clk;
  logic        i_rst, i_mode, i_w_load, i_a_valid, i_drain;
  logic [7:0]  i_w_in, i_a_in;
  logic [31:0] i_ps_s_in, i_ps_c_in;
  logic        o_a_ready, o_a_out_vld, o_res_valid;
  logic [7:0]  o_a_out;
  logic [31:0] o_ps_s_out, o_ps_c_out, o_res_data;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: weight, running integer sum, and whether a result is being produced.
  logic [7:0]  m_w;
  logic [31:0] m_sum;
  bit          m_accum, m_resolving;
  logic [7:0]  e_a_out;
  bit          e_vld, e_res_valid, e_ps_summed;
  logic [31:0] e_res_data, e_ps_s, e_ps_c, e_ps_sum;

  ws_csa_pe #(.DATA_W(8), .ACC_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mode      (i_mode),
    .i_w_load    (i_w_load),
    .i_w_in      (i_w_in),
    .i_a_valid   (i_a_valid),
    .o_a_ready   (o_a_ready),
    .i_a_in      (i_a_in),
    .i_ps_s_in   (i_ps_s_in),
    .i_ps_c_in   (i_ps_c_in),
    .o_a_out     (o_a_out),
    .o_a_out_vld (o_a_out_vld),
    .o_ps_s_out  (o_ps_s_out),
    .o_ps_c_out  (o_ps_c_out),
    .i_drain     (i_drain),
    .o_res_data  (o_res_data),
    .o_res_valid (o_res_valid)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock with the current inputs, updating the model, then compare every output.
  task automatic step();
    logic signed [7:0] sa, sw;
    int          prod;
    logic [31:0] prod32;
    bit          acc, os;
    sa     = i_a_in;
    sw     = m_w;
    prod   = sa * sw;
    prod32 = prod;
    acc    = i_a_valid && !m_resolving;
    os     = (m_resolving || m_accum) ? 1'b1 : i_mode;
    if (i_rst) begin
      m_w = 0; m_sum = 0; m_accum = 0; m_resolving = 0;
      e_a_out = 0; e_vld = 0; e_res_valid = 0; e_res_data = 0;
      e_ps_summed = 0; e_ps_s = 0; e_ps_c = 0;
    end else begin
      if (acc) e_a_out = i_a_in;
      e_vld = acc;
      if (!os && acc) begin
        e_ps_summed = 1;
        e_ps_sum    = i_ps_s_in + i_ps_c_in + prod32;
      end else begin
        e_ps_summed = 0;
        e_ps_s      = i_ps_s_in;
        e_ps_c      = i_ps_c_in;
      end
      e_res_valid = 0;
      if (m_resolving) begin
        e_res_data  = m_sum;
        e_res_valid = 1;
        m_sum       = 0;
        m_resolving = 0;
      end else if (os) begin
        if (acc) begin
          m_sum   = m_sum + prod32;
          m_accum = 1;
        end
        if (i_drain) begin
          m_resolving = 1;
          m_accum     = 0;
        end
      end
      if (i_w_load) m_w = i_w_in;
    end
    @(posedge i_clk);
    #1;
    chk("a_ready", {31'd0, o_a_ready}, {31'd0, !m_resolving});
    chk("a_out", {24'd0, o_a_out}, {24'd0, e_a_out});
    chk("a_out_vld", {31'd0, o_a_out_vld}, {31'd0, e_vld});
    chk("res_valid", {31'd0, o_res_valid}, {31'd0, e_res_valid});
    chk("res_data", o_res_data, e_res_data);
    if (e_ps_summed) begin
      chk("ps_sum", o_ps_s_out + o_ps_c_out, e_ps_sum);
    end else begin
      chk("ps_s_bypass", o_ps_s_out, e_ps_s);
      chk("ps_c_bypass", o_ps_c_out, e_ps_c);
    end
  endtask

  task automatic idle_inputs();
    i_rst = 0; i_w_load = 0; i_a_valid = 0; i_drain = 0;
  endtask

  initial begin
    m_w = 0; m_sum = 0; m_accum = 0; m_resolving = 0;
    e_a_out = 0; e_vld = 0; e_res_valid = 0; e_res_data = 0;
    e_ps_summed = 0; e_ps_s = 0; e_ps_c = 0; e_ps_sum = 0;

    // Reset with random inputs on every other pin
    i_rst = 1;
    for (int i = 0; i < 2; i++) begin
      i_mode = 1'($urandom); i_w_load = 1'($urandom); i_w_in = 8'($urandom);
      i_a_valid = 1'($urandom); i_a_in = 8'($urandom); i_drain = 1'($urandom);
      i_ps_s_in = $urandom; i_ps_c_in = $urandom;
      step();
    end
    chk("rst_ps_s", o_ps_s_out, 32'd0);
    chk("rst_ready", {31'd0, o_a_ready}, 32'd1);

    // WS: 100 + 3*(-5) = 85
    idle_inputs();
    i_mode = 0; i_ps_s_in = 0; i_ps_c_in = 0;
    i_w_load = 1; i_w_in = 8'd3;
    step();
    i_w_load = 0; i_a_valid = 1; i_a_in = 8'hFB; i_ps_s_in = 32'd100; i_ps_c_in = 32'd0;
    step();
    chk("ws_85", o_ps_s_out + o_ps_c_out, 32'd85);
    chk("ws_a_out", {24'd0, o_a_out}, 32'h0000_00FB);

    // OS: w=-2, a=1..4, drain with the last accept -> -20
    idle_inputs();
    i_mode = 1; i_w_load = 1; i_w_in = 8'hFE;
    step();
    i_w_load = 0;
    for (int a = 1; a <= 4; a++) begin
      i_a_valid = 1; i_a_in = 8'(a); i_drain = (a == 4);
      step();
    end
    chk("os_ready_low", {31'd0, o_a_ready}, 32'd0);
    idle_inputs();
    step();
    chk("os_res_valid", {31'd0, o_res_valid}, 32'd1);
    chk("os_res_m20", o_res_data, 32'hFFFF_FFEC);
    chk("os_ready_back", {31'd0, o_a_ready}, 32'd1);
    step();
    chk("os_pulse_end", {31'd0, o_res_valid}, 32'd0);

    // Weight swap on the accept cycle: 2*1 then 2*7
    i_mode = 1; i_w_load = 1; i_w_in = 8'd1;
    step();
    i_w_in = 8'd7; i_a_valid = 1; i_a_in = 8'd2;
    step();
    i_w_load = 0;
    step();
    idle_inputs(); i_drain = 1;
    step();
    idle_inputs();
    step();
    chk("wswap_16", o_res_data, 32'd16);

    // Extremes: WS psum wrap at 2^31, then long OS run of (-128)*(-128)
    i_mode = 0; i_w_load = 1; i_w_in = 8'h80;
    step();
    i_w_load = 0; i_a_valid = 1; i_a_in = 8'h80; i_ps_s_in = 32'h7FFF_FFFF; i_ps_c_in = 32'd0;
    step();
    chk("ws_wrap", o_ps_s_out + o_ps_c_out, 32'h8000_3FFF);
    idle_inputs(); i_mode = 1; i_ps_s_in = 0;
    step();
    for (int i = 0; i < 1000; i++) begin
      i_a_valid = 1; i_a_in = 8'h80;
      step();
    end
    idle_inputs(); i_drain = 1;
    step();
    idle_inputs();
    step();
    chk("os_extreme", o_res_data, 32'd16384000);

    // Reset mid-accumulation discards the sum; next accumulation starts from zero
    i_w_load = 1; i_w_in = 8'd9;
    step();
    i_w_load = 0;
    for (int i = 0; i < 3; i++) begin
      i_a_valid = 1; i_a_in = 8'(i + 1);
      step();
    end
    idle_inputs(); i_rst = 1;
    step();
    idle_inputs(); i_mode = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_res", {31'd0, o_res_valid}, 32'd0);
    end
    i_w_load = 1; i_w_in = 8'd3;
    step();
    i_w_load = 0; i_a_valid = 1; i_a_in = 8'd5; i_drain = 1;
    step();
    idle_inputs();
    step();
    chk("fresh_15", o_res_data, 32'd15);
    chk("fresh_valid", {31'd0, o_res_valid}, 32'd1);

    // Random traffic, including mode flips mid-accumulation and occasional resets
    for (int i = 0; i < 4000; i++) begin
      i_rst     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
      i_w_load  = ($urandom_range(0, 7) == 0);
      i_w_in    = 8'($urandom);
      i_a_valid = ($urandom_range(0, 3) != 0);
      i_a_in    = 8'($urandom);
      i_drain   = ($urandom_range(0, 19) == 0);
      i_ps_s_in = $urandom;
      i_ps_c_in = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
